bcd_counter4: RTL and testbench

Four-digit decimal up/down counter with a built-in prescaler. It produces the four BCD nibbles that drive the board's hex-digit seven-segment decoders, one nibble per display. It runs in the lab display path as the value source, for example a stopwatch or event counter, directly upstream of the segment decoders. Every output is registered, so the downstream decoders see glitch-free nibbles.

---
 rtl/bcd_counter4.sv | 120 ++++++++++++
 tb/tb_bcd_counter4.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter4.sv
// bcd_counter4: four-digit BCD up/down counter with a built-in prescaler.
// Drives one BCD nibble per seven-segment decoder. All outputs come straight
// from registers, so the decoders never see glitches.
module bcd_counter4 #(
  parameter int TICK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic [3:0]  digit0,
  output logic        step,
  output logic        wrap
);

  // Prescaler width: TICK_DIV-1 must fit; a one-cycle divider still needs 1 bit.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_pcnt;
  logic [3:0]    r_digit [4];
  logic          r_step;
  logic          r_wrap;

  logic [3:0]    w_next [4];
  logic          w_carry;
  logic          w_wrap;
  logic          w_tick;
  logic [3:0]    w_load [4];

  // Clamp a load nibble into the legal BCD range so digits stay 0 to 9.
  function automatic logic [3:0] satNibble(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // A load on the terminal-count cycle wins, so it masks the tick here.
  assign w_tick = en && !load && (r_pcnt == PCNT_LAST);

  // Saturated load value, one entry per digit, LSD at index 0.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_load[i] = satNibble(load_val[4*i +: 4]);
    end
  end

  // Ripple the carry/borrow through all four digits in one cycle; a carry
  // out of the MSD means the whole counter wrapped (9999->0000 or back).
  always_comb begin
    w_carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_next[i] = r_digit[i];
      if (w_carry) begin
        if (up) begin
          if (r_digit[i] >= 4'd9) begin
            w_next[i] = 4'd0;
          end else begin
            w_next[i] = r_digit[i] + 4'd1;
            w_carry   = 1'b0;
          end
        end else begin
          if (r_digit[i] == 4'd0) begin
            w_next[i] = 4'd9;
          end else begin
            w_next[i] = r_digit[i] - 4'd1;
            w_carry   = 1'b0;
          end
        end
      end
    end
    w_wrap = w_carry;
  end

  // State update in priority order: reset, load, enabled count, hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcnt <= '0;
      r_step <= 1'b0;
      r_wrap <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_digit[i] <= 4'd0;
      end
    end else if (load) begin
      r_pcnt <= '0;
      r_step <= 1'b0;
      r_wrap <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_digit[i] <= w_load[i];
      end
    end else if (en) begin
      if (r_pcnt == PCNT_LAST) begin
        r_pcnt <= '0;
      end else begin
        r_pcnt <= r_pcnt + 1'b1;
      end
      r_step <= w_tick;
      r_wrap <= w_tick && w_wrap;
      if (w_tick) begin
        for (int i = 0; i < 4; i++) begin
          r_digit[i] <= w_next[i];
        end
      end
    end else begin
      r_step <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  assign digit3 = r_digit[3];
  assign digit2 = r_digit[2];
  assign digit1 = r_digit[1];
  assign digit0 = r_digit[0];
  assign step   = r_step;
  assign wrap   = r_wrap;

endmodule

// File: tb/tb_bcd_counter4.sv
// tb_bcd_counter4: directed self-checking bench for bcd_counter4 at TICK_DIV=4.
module tb_bcd_counter4;

  logic        clk;
  logic        reset;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic [3:0]  digit3;
  logic [3:0]  digit2;
  logic [3:0]  digit1;
  logic [3:0]  digit0;
  logic        step;
  logic        wrap;

  int errors;
  int checks;

  logic [15:0] w_digits;
  assign w_digits = {digit3, digit2, digit1, digit0};

  bcd_counter4 #(.TICK_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .digit3   (digit3),
    .digit2   (digit2),
    .digit1   (digit1),
    .digit0   (digit0),
    .step     (step),
    .wrap     (wrap)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge, then settle on the falling edge for sampling.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // One-cycle load pulse of the given value.
  task automatic doLoad(input logic [15:0] v);
    load     = 1'b1;
    load_val = v;
    cyc(1);
    load     = 1'b0;
  endtask

  // Reset values, then sixteen enabled up-count cycles.
  task automatic test_reset;
    int pulses;
    logic [15:0] expD;
    logic expS;
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 16'h0000;
    cyc(2);
    checks++;
    if (w_digits !== 16'h0000 || step !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: digits=%h step=%b wrap=%b, want 0000 0 0", w_digits, step, wrap);
    end
    reset = 1'b0; en = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      cyc(1);
      expD = 16'(i / 4);
      expS = (i % 4 == 0);
      if (step === 1'b1) pulses++;
      checks++;
      if (w_digits !== expD || step !== expS || wrap !== 1'b0) begin
        errors++;
        $display("[TB] FAIL count_up cyc%0d: digits=%h step=%b wrap=%b, want %h %b 0", i, w_digits, step, wrap, expD, expS);
      end
    end
    checks++;
    if (pulses !== 4) begin
      errors++;
      $display("[TB] FAIL step_pulses: got %0d, want 4", pulses);
    end
  endtask

  // 0998 -> 0999 -> 1000, the full ripple happening in one step.
  task automatic test_ripple;
    en = 1'b1; up = 1'b1;
    doLoad(16'h0998);
    checks++;
    if (w_digits !== 16'h0998 || step !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ripple_load: digits=%h step=%b, want 0998 0", w_digits, step);
    end
    cyc(4);
    checks++;
    if (w_digits !== 16'h0999 || step !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ripple_0999: digits=%h step=%b, want 0999 1", w_digits, step);
    end
    cyc(3);
    checks++;
    if (w_digits !== 16'h0999 || step !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ripple_hold: digits=%h step=%b, want 0999 0", w_digits, step);
    end
    cyc(1);
    checks++;
    if (w_digits !== 16'h1000 || step !== 1'b1 || wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ripple_1000: digits=%h step=%b wrap=%b, want 1000 1 0", w_digits, step, wrap);
    end
  endtask

  // Wrap in both directions, plus a borrow ripple 1000 -> 0999.
  task automatic test_wrap;
    en = 1'b1; up = 1'b1;
    doLoad(16'h9999);
    cyc(4);
    checks++;
    if (w_digits !== 16'h0000 || step !== 1'b1 || wrap !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_up: digits=%h step=%b wrap=%b, want 0000 1 1", w_digits, step, wrap);
    end
    cyc(1);
    checks++;
    if (step !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_up_width: step=%b wrap=%b, want 0 0", step, wrap);
    end
    up = 1'b0;
    doLoad(16'h0000);
    cyc(4);
    checks++;
    if (w_digits !== 16'h9999 || step !== 1'b1 || wrap !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_down: digits=%h step=%b wrap=%b, want 9999 1 1", w_digits, step, wrap);
    end
    cyc(1);
    checks++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wrap_down_width: wrap=%b, want 0", wrap);
    end
    doLoad(16'h1000);
    cyc(4);
    checks++;
    if (w_digits !== 16'h0999 || step !== 1'b1 || wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL borrow_ripple: digits=%h step=%b wrap=%b, want 0999 1 0", w_digits, step, wrap);
    end
  endtask

  // Out-of-range nibbles saturate to 9.
  task automatic test_saturate;
    en = 1'b0; up = 1'b1;
    doLoad(16'hA3F7);
    checks++;
    if (w_digits !== 16'h9397 || step !== 1'b0) begin
      errors++;
      $display("[TB] FAIL saturate: digits=%h step=%b, want 9397 0", w_digits, step);
    end
    en = 1'b1;
    cyc(4);
    checks++;
    if (w_digits !== 16'h9398) begin
      errors++;
      $display("[TB] FAIL saturate_step: digits=%h, want 9398", w_digits);
    end
  endtask

  // Load on the terminal-count cycle suppresses the step and restarts the period.
  task automatic test_load_on_tick;
    int bad;
    en = 1'b1; up = 1'b1;
    doLoad(16'h1234);
    cyc(3);
    doLoad(16'h0500);
    checks++;
    if (w_digits !== 16'h0500 || step !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_wins: digits=%h step=%b, want 0500 0", w_digits, step);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      if (step !== 1'b0 || w_digits !== 16'h0500) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL load_restart_early: %0d bad cycles, want 0", bad);
    end
    cyc(1);
    checks++;
    if (w_digits !== 16'h0501 || step !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_restart_step: digits=%h step=%b, want 0501 1", w_digits, step);
    end
  endtask

  // Pausing freezes the prescaler; reset with load clears everything.
  task automatic test_pause_reset;
    int bad;
    en = 1'b1; up = 1'b1;
    doLoad(16'h0042);
    cyc(2);
    en = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (step !== 1'b0 || w_digits !== 16'h0042) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL pause_hold: %0d bad cycles, want 0", bad);
    end
    en = 1'b1;
    cyc(1);
    checks++;
    if (step !== 1'b0 || w_digits !== 16'h0042) begin
      errors++;
      $display("[TB] FAIL resume_early: digits=%h step=%b, want 0042 0", w_digits, step);
    end
    cyc(1);
    checks++;
    if (step !== 1'b1 || w_digits !== 16'h0043) begin
      errors++;
      $display("[TB] FAIL resume_step: digits=%h step=%b, want 0043 1", w_digits, step);
    end
    cyc(2);
    reset = 1'b1; load = 1'b1; load_val = 16'h7777;
    cyc(2);
    checks++;
    if (w_digits !== 16'h0000 || step !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_over_load: digits=%h step=%b wrap=%b, want 0000 0 0", w_digits, step, wrap);
    end
    reset = 1'b0; load = 1'b0;
    cyc(3);
    checks++;
    if (step !== 1'b0 || w_digits !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_restart_early: digits=%h step=%b, want 0000 0", w_digits, step);
    end
    cyc(1);
    checks++;
    if (step !== 1'b1 || w_digits !== 16'h0001) begin
      errors++;
      $display("[TB] FAIL reset_restart_step: digits=%h step=%b, want 0001 1", w_digits, step);
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 16'h0000;
    test_reset();
    test_ripple();
    test_wrap();
    test_saturate();
    test_load_on_tick();
    test_pause_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
